// File: rtl/upm_cbb_chain_driver_if.sv
// upm_cbb_chain_driver_if: request/response handshake bundle between a host and the chain driver
interface upm_cbb_chain_driver_if #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W = $clog2(MAX_LEN + 1)
);
  logic req_valid;
  logic req_ready;
  logic [CNT_W-1:0] req_len;
  logic [MAX_LEN-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [MAX_LEN-1:0] rsp_rdata;
  logic [1:0] rsp_status;
  modport master (
    output req_valid, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status
  );
  modport slave (
    input  req_valid, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_status
  );
endinterface

// File: rtl/upm_cbb_chain_driver.sv
// upm_cbb_chain_driver: sequences capture/shift/update on a CBB TDR chain, serializing write data
// and collecting readback plus power-enable error status for each request
module upm_cbb_chain_driver #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic tck,
  input  logic fdfx_powergood,
  upm_cbb_chain_driver_if.slave bus,
  output logic sel,
  output logic capture,
  output logic shift,
  output logic update,
  output logic si,
  input  logic so,
  input  logic power_enable_error_next
);
  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, RESP} state_t;
  state_t state_q;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic [MAX_LEN-1:0] wdata_q, rdata_q, bit_q;
  logic [1:0] status_q;
  logic err_q, sel_q, capture_q, shift_q, update_q, si_q;
  logic err_d, bad_len, last;
  always_comb begin
    err_d = err_q | (sel_q & power_enable_error_next);
    bad_len = (bus.req_len == '0) || (bus.req_len > CNT_W'(MAX_LEN));
    last = cnt_q == len_q - CNT_W'(1);
  end
  // wdata_q shifts right so si always comes from bit 0; bit_q is a one-hot write pointer into rdata_q
  always_ff @(posedge tck or negedge fdfx_powergood) begin
    if (!fdfx_powergood) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bit_q <= '0;
      status_q <= 2'b00;
      err_q <= 1'b0;
      sel_q <= 1'b0;
      capture_q <= 1'b0;
      shift_q <= 1'b0;
      update_q <= 1'b0;
      si_q <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          len_q <= bus.req_len;
          wdata_q <= bus.req_wdata;
          rdata_q <= '0;
          bit_q <= MAX_LEN'(1);
          cnt_q <= '0;
          err_q <= 1'b0;
          status_q <= bad_len ? 2'b01 : 2'b00;
          state_q <= bad_len ? RESP : CAPTURE;
          sel_q <= !bad_len;
          capture_q <= !bad_len;
        end
        CAPTURE: begin
          capture_q <= 1'b0;
          shift_q <= 1'b1;
          si_q <= wdata_q[0];
          wdata_q <= wdata_q >> 1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          rdata_q <= rdata_q | (so ? bit_q : '0);
          bit_q <= bit_q << 1;
          cnt_q <= last ? cnt_q : cnt_q + CNT_W'(1);
          si_q <= last ? 1'b0 : wdata_q[0];
          wdata_q <= wdata_q >> 1;
          shift_q <= !last;
          update_q <= last;
          state_q <= last ? UPDATE : SHIFT;
        end
        UPDATE: begin
          sel_q <= 1'b0;
          update_q <= 1'b0;
          status_q <= err_d ? 2'b10 : 2'b00;
          state_q <= RESP;
        end
        RESP: state_q <= bus.rsp_ready ? IDLE : RESP;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_status = status_q;
  assign sel = sel_q;
  assign capture = capture_q;
  assign shift = shift_q;
  assign update = update_q;
  assign si = si_q;
  a_excl: assert property (@(posedge tck) disable iff (!fdfx_powergood)
    $onehot0({capture_q, shift_q, update_q}));
  a_sel: assert property (@(posedge tck) disable iff (!fdfx_powergood)
    (capture_q | shift_q | update_q) |-> sel_q);
endmodule

// File: tb/tb_upm_cbb_chain_driver.sv
// tb_upm_cbb_chain_driver: directed requests against an 8-deep loopback chain model, scoreboarded responses
module tb_upm_cbb_chain_driver;
  localparam int ML = 64;
  localparam int CW = $clog2(ML + 1);
  typedef struct packed {
    logic [ML-1:0] rd;
    logic [1:0] st;
  } exp_t;
  logic tck = 1'b0;
  logic rst_n = 1'b0;
  logic pee = 1'b0;
  logic so, sel, capture, shift, update, si;
  logic so_mode = 1'b0;
  logic so_const = 1'b0;
  logic [7:0] model = 8'h00;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t mon_e;
  upm_cbb_chain_driver_if #(.MAX_LEN(ML)) bus ();
  upm_cbb_chain_driver #(.MAX_LEN(ML)) dut (
    .tck(tck),
    .fdfx_powergood(rst_n),
    .bus(bus.slave),
    .sel(sel),
    .capture(capture),
    .shift(shift),
    .update(update),
    .si(si),
    .so(so),
    .power_enable_error_next(pee)
  );
  always #5 tck = ~tck;
  assign so = so_mode ? so_const : model[0];
  always @(posedge tck) if (shift) model <= {si, model[7:1]};
  task automatic chk(input string nm, input logic [ML-1:0] act, input logic [ML-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  always @(negedge tck) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rd);
        chk("rsp_status", ML'(bus.rsp_status), ML'(mon_e.st));
      end
    end
  end
  task automatic run_req(input int len, input logic [ML-1:0] wd, input logic [ML-1:0] er,
                         input logic [1:0] es, input int stall, input int err_at);
    int c, cap_c, upd_c, rv_c, nshift, sel_cnt;
    logic [ML-1:0] rd0;
    logic [1:0] st0;
    q.push_back('{rd: er, st: es});
    @(posedge tck); #1;
    bus.rsp_ready = (stall == 0);
    bus.req_valid = 1'b1;
    bus.req_len = CW'(len);
    bus.req_wdata = wd;
    @(negedge tck);
    chk("req_ready_idle", ML'(bus.req_ready), 1);
    @(posedge tck); #1;
    bus.req_valid = 1'b0;
    c = 0; cap_c = -1; upd_c = -1; rv_c = -1; nshift = 0; sel_cnt = 0;
    while (rv_c < 0 && c < 300) begin
      @(negedge tck);
      c++;
      if (capture && cap_c < 0) cap_c = c;
      if (shift) nshift++;
      if (update) upd_c = c;
      if (sel) sel_cnt++;
      if (bus.rsp_valid) rv_c = c;
      pee = (c == err_at);
    end
    pee = 1'b0;
    if (es == 2'b01) begin
      chk("bad_rsp_cycle", ML'(rv_c), 1);
      chk("bad_no_sel", ML'(sel_cnt), 0);
    end else begin
      chk("capture_cycle", ML'(cap_c), 1);
      chk("shift_count", ML'(nshift), ML'(len));
      chk("update_cycle", ML'(upd_c), ML'(len + 2));
      chk("rsp_cycle", ML'(rv_c), ML'(len + 3));
      chk("sel_cycles", ML'(sel_cnt), ML'(len + 2));
    end
    if (stall > 0) begin
      rd0 = bus.rsp_rdata;
      st0 = bus.rsp_status;
      for (int k = 0; k < stall; k++) begin
        @(posedge tck); #1;
        if (k == 0) begin
          bus.req_valid = 1'b1;
          bus.req_len = CW'(8);
          bus.req_wdata = {ML{1'b1}};
        end
        @(negedge tck);
        chk("stall_valid", ML'(bus.rsp_valid), 1);
        chk("stall_rdata", bus.rsp_rdata, rd0);
        chk("stall_status", ML'(bus.rsp_status), ML'(st0));
      end
      @(posedge tck); #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge tck);
    end
    @(posedge tck); #1;
    @(negedge tck);
    chk("ready_after_rsp", ML'({bus.req_ready, bus.rsp_valid, sel}), ML'(3'b100));
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_len = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge tck);
    chk("rst_ctrl", ML'({sel, capture, shift, update, si, bus.rsp_valid}), 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_status", ML'(bus.rsp_status), 0);
    #1 rst_n = 1'b1;
    @(negedge tck);
    chk("rst_req_ready", ML'(bus.req_ready), 1);
    run_req(8, 'hA5, 'h00, 2'b00, 0, 0);
    run_req(8, 'hA5, 'hA5, 2'b00, 0, 0);
    run_req(0, 'hFF, 'h00, 2'b01, 0, 0);
    run_req(ML + 1, 'hFF, 'h00, 2'b01, 0, 0);
    so_mode = 1'b1; so_const = 1'b1;
    run_req(ML, {ML{1'b1}}, {ML{1'b1}}, 2'b00, 0, 0);
    so_mode = 1'b0;
    run_req(8, 'h3C, 'hFF, 2'b10, 0, 4);
    run_req(8, 'h00, 'h3C, 2'b00, 0, 0);
    so_mode = 1'b1;
    @(posedge tck); #1;
    bus.req_valid = 1'b1;
    bus.req_len = CW'(8);
    bus.req_wdata = 'hFF;
    @(posedge tck); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge tck);
    chk("mid_shift", ML'(shift), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", ML'({sel, capture, shift, update, si, bus.rsp_valid}), 0);
    chk("async_rst_rdata", bus.rsp_rdata, 0);
    begin
      int act = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge tck);
        if (sel || update || bus.rsp_valid) act++;
      end
      chk("rst_no_activity", ML'(act), 0);
    end
    #1 rst_n = 1'b1;
    @(negedge tck);
    chk("post_rst_idle", ML'({bus.req_ready, bus.rsp_valid, sel}), ML'(3'b100));
    run_req(4, 'hA, 'hF, 2'b00, 0, 0);
    run_req(5, 'h15, 'h1F, 2'b00, 5, 0);
    chk("sb_empty", ML'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
